// File: rtl/thread_sched_pkg.sv
// Shared constants and types for the barrel thread scheduler.
// Thread tags, state encoding and reset tag values.
package thread_sched_pkg;

  localparam int NUM_THREADS = 4;
  localparam int TID_W       = 2;

  typedef logic [TID_W-1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam tid_t RST_IF = 2'd0;
  localparam tid_t RST_ID = 2'd3;
  localparam tid_t RST_EX = 2'd2;
  localparam tid_t RST_WB = 2'd1;

endpackage

// File: rtl/thread_valid_pipe.sv
// Three-stage valid/tag shift register behind the fetch slot.
// Holds on stall, clears valids when idle, reloads tags on launch.
module thread_valid_pipe
  import thread_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic load,
  input  logic flush,
  input  logic valid_in,
  input  tid_t tag_in,
  output logic valid_id,
  output logic valid_ex,
  output logic valid_wb,
  output tid_t tag_id,
  output tid_t tag_ex,
  output tid_t tag_wb
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_id <= 1'b0;
      valid_ex <= 1'b0;
      valid_wb <= 1'b0;
      tag_id   <= RST_ID;
      tag_ex   <= RST_EX;
      tag_wb   <= RST_WB;
    end else if (load) begin
      valid_id <= 1'b0;
      valid_ex <= 1'b0;
      valid_wb <= 1'b0;
      tag_id   <= RST_ID;
      tag_ex   <= RST_EX;
      tag_wb   <= RST_WB;
    end else if (flush) begin
      valid_id <= 1'b0;
      valid_ex <= 1'b0;
      valid_wb <= 1'b0;
    end else if (adv) begin
      valid_id <= valid_in;
      valid_ex <= valid_id;
      valid_wb <= valid_ex;
      tag_id   <= tag_in;
      tag_ex   <= tag_id;
      tag_wb   <= tag_ex;
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Barrel scheduler for the 4-thread pipeline: rotates thread tags,
// tracks live threads, drains on last halt and qualifies branches.
module thread_sched
  import thread_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_THREADS-1:0] thread_en_init,
  input  logic                   stall,
  input  logic                   halt_req,
  input  logic [TID_W-1:0]       halt_tid,
  input  logic                   br_taken,
  output logic [TID_W-1:0]       thread_IF,
  output logic [TID_W-1:0]       thread_ID,
  output logic [TID_W-1:0]       thread_EX,
  output logic [TID_W-1:0]       thread_WB,
  output logic                   valid_IF,
  output logic                   valid_ID,
  output logic                   valid_EX,
  output logic                   valid_WB,
  output logic                   PC_ctrl,
  output logic [NUM_THREADS-1:0] active_mask,
  output logic                   all_done
);

  state_t state, state_nxt;
  logic [NUM_THREADS-1:0] mask_nxt;
  logic [NUM_THREADS-1:0] mask_clr;
  logic done_nxt;
  logic idle_like;
  logic launch;
  logic adv;
  logic halt_hit;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign launch    = idle_like && start && (|thread_en_init);
  assign adv       = !stall && ((state == RUN) || (state == DRAIN));
  assign halt_hit  = (state == RUN) && halt_req && !stall
                   && valid_ID && (halt_tid == thread_ID);

  assign valid_IF = (state == RUN) && active_mask[thread_IF];
  assign PC_ctrl  = br_taken && valid_ID && !stall;

  always_comb begin
    state_nxt = state;
    mask_nxt  = active_mask;
    done_nxt  = all_done;
    mask_clr  = active_mask;
    mask_clr[halt_tid] = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (launch) begin
          state_nxt = RUN;
          mask_nxt  = thread_en_init;
          done_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (halt_hit) begin
          mask_nxt = mask_clr;
          if (mask_clr == '0) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // ID/EX after the shift come from IF(=0) and ID
        if (adv && !valid_ID && !valid_EX) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      thread_IF   <= RST_IF;
      active_mask <= '0;
      all_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      active_mask <= mask_nxt;
      all_done    <= done_nxt;
      if (launch) thread_IF <= RST_IF;
      else if (adv) thread_IF <= thread_IF + tid_t'(1);
    end
  end

  thread_valid_pipe u_pipe (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .load     (launch),
    .flush    (idle_like),
    .valid_in (valid_IF),
    .tag_in   (thread_IF),
    .valid_id (valid_ID),
    .valid_ex (valid_EX),
    .valid_wb (valid_WB),
    .tag_id   (thread_ID),
    .tag_ex   (thread_EX),
    .tag_wb   (thread_WB)
  );

endmodule

// File: tb/tb_thread_sched.sv
// Bench for thread_sched: directed vector table, async reset,
// halt-all/relaunch sequence and random run against a model.
module tb_thread_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] thread_en_init = 4'h0;
  logic       stall = 1'b0;
  logic       halt_req = 1'b0;
  logic [1:0] halt_tid = 2'd0;
  logic       br_taken = 1'b0;
  logic [1:0] thread_IF, thread_ID, thread_EX, thread_WB;
  logic       valid_IF, valid_ID, valid_EX, valid_WB;
  logic       PC_ctrl, all_done;
  logic [3:0] active_mask;

  int total = 0;
  int bad = 0;

  thread_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .thread_en_init(thread_en_init), .stall(stall),
    .halt_req(halt_req), .halt_tid(halt_tid), .br_taken(br_taken),
    .thread_IF(thread_IF), .thread_ID(thread_ID),
    .thread_EX(thread_EX), .thread_WB(thread_WB),
    .valid_IF(valid_IF), .valid_ID(valid_ID),
    .valid_EX(valid_EX), .valid_WB(valid_WB),
    .PC_ctrl(PC_ctrl), .active_mask(active_mask),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases 0 idle, 1 run, 2 drain, 3 done.
  int       m_st;
  int       m_if;
  bit [3:0] m_mask;
  bit       m_vid, m_vex, m_vwb, m_done;

  task automatic m_init();
    m_st = 0; m_if = 0; m_mask = 4'h0;
    m_vid = 0; m_vex = 0; m_vwb = 0; m_done = 0;
  endtask

  function automatic int m_id();
    return (m_if + 3) % 4;
  endfunction

  task automatic m_step(input bit s, input bit [3:0] init, input bit st,
                        input bit hr, input bit [1:0] ht);
    bit vif;
    bit halt;
    vif = (m_st == 1) && m_mask[m_if];
    if (m_st == 0 || m_st == 3) begin
      if (s && init != 0) begin
        m_st = 1; m_mask = init; m_if = 0;
        m_vid = 0; m_vex = 0; m_vwb = 0; m_done = 0;
      end
      return;
    end
    if (st) return;
    halt = (m_st == 1) && hr && (int'(ht) == m_id()) && m_vid;
    m_vwb = m_vex; m_vex = m_vid; m_vid = vif;
    m_if = (m_if + 1) % 4;
    if (halt) begin
      m_mask[ht] = 1'b0;
      if (m_mask == 0) m_st = 2;
    end else if (m_st == 2 && !m_vid && !m_vex && !m_vwb) begin
      m_st = 3; m_done = 1;
    end
  endtask

  task automatic m_check(input bit st, input bit br);
    chk("tag_if", thread_IF, m_if);
    chk("tag_id", thread_ID, (m_if + 3) % 4);
    chk("tag_ex", thread_EX, (m_if + 2) % 4);
    chk("tag_wb", thread_WB, (m_if + 1) % 4);
    chk("v_if", valid_IF, (m_st == 1) && m_mask[m_if]);
    chk("v_id", valid_ID, m_vid);
    chk("v_ex", valid_EX, m_vex);
    chk("v_wb", valid_WB, m_vwb);
    chk("mask", active_mask, m_mask);
    chk("done", all_done, m_done);
    chk("pc_ctrl", PC_ctrl, br && m_vid && !st);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic mcyc(input bit s, input bit [3:0] init, input bit st,
                      input bit hr, input bit [1:0] ht, input bit br);
    start = s; thread_en_init = init; stall = st;
    halt_req = hr; halt_tid = ht; br_taken = br;
    #1;
    m_check(st, br);
    @(posedge clk);
    m_step(s, init, st, hr, ht);
    @(negedge clk);
  endtask

  typedef struct {
    logic       s;
    logic [3:0] init;
    logic       st, hr;
    logic [1:0] ht;
    logic       br;
    logic [1:0] e_if, e_id;
    logic       e_vif, e_vid, e_vwb;
    logic [3:0] e_mask;
    logic       e_done, e_pc;
  } vec_t;

  vec_t tbl[13];
  int   n;
  int   zero_cnt;

  initial begin
    tbl[0]  = '{0, 4'h0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 4'h0, 0, 0};
    tbl[1]  = '{1, 4'hF, 0, 0, 0, 0, 0, 3, 0, 0, 0, 4'h0, 0, 0};
    tbl[2]  = '{0, 4'h0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 4'hF, 0, 0};
    tbl[3]  = '{0, 4'h0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 4'hF, 0, 0};
    tbl[4]  = '{0, 4'h0, 0, 1, 1, 1, 2, 1, 1, 1, 0, 4'hF, 0, 1};
    tbl[5]  = '{0, 4'h0, 0, 0, 0, 0, 3, 2, 1, 1, 1, 4'hD, 0, 0};
    tbl[6]  = '{0, 4'h0, 1, 1, 3, 1, 0, 3, 1, 1, 1, 4'hD, 0, 0};
    tbl[7]  = '{0, 4'h0, 1, 1, 3, 1, 0, 3, 1, 1, 1, 4'hD, 0, 0};
    tbl[8]  = '{0, 4'h0, 0, 1, 2, 0, 0, 3, 1, 1, 1, 4'hD, 0, 0};
    tbl[9]  = '{0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 4'hD, 0, 0};
    tbl[10] = '{0, 4'h0, 0, 1, 1, 1, 2, 1, 1, 0, 1, 4'hD, 0, 0};
    tbl[11] = '{0, 4'h0, 0, 0, 0, 0, 3, 2, 1, 1, 1, 4'hD, 0, 0};
    tbl[12] = '{0, 4'h0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 4'hD, 0, 0};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      start = tbl[i].s; thread_en_init = tbl[i].init;
      stall = tbl[i].st; halt_req = tbl[i].hr;
      halt_tid = tbl[i].ht; br_taken = tbl[i].br;
      #1;
      chk($sformatf("r%0d_if", i), thread_IF, tbl[i].e_if);
      chk($sformatf("r%0d_id", i), thread_ID, tbl[i].e_id);
      chk($sformatf("r%0d_ex", i), thread_EX, (tbl[i].e_if + 2) % 4);
      chk($sformatf("r%0d_wb", i), thread_WB, (tbl[i].e_if + 1) % 4);
      chk($sformatf("r%0d_vif", i), valid_IF, tbl[i].e_vif);
      chk($sformatf("r%0d_vid", i), valid_ID, tbl[i].e_vid);
      chk($sformatf("r%0d_vwb", i), valid_WB, tbl[i].e_vwb);
      chk($sformatf("r%0d_mask", i), active_mask, tbl[i].e_mask);
      chk($sformatf("r%0d_done", i), all_done, tbl[i].e_done);
      chk($sformatf("r%0d_pc", i), PC_ctrl, tbl[i].e_pc);
      @(negedge clk);
    end

    // Asynchronous reset between edges while running.
    start = 0; stall = 0; halt_req = 0; br_taken = 1;
    #2 rst = 1'b0;
    #1;
    chk("ar_if", thread_IF, 0);
    chk("ar_id", thread_ID, 3);
    chk("ar_ex", thread_EX, 2);
    chk("ar_wb", thread_WB, 1);
    chk("ar_valids", {valid_IF, valid_ID, valid_EX, valid_WB}, 0);
    chk("ar_mask", active_mask, 0);
    chk("ar_done", all_done, 0);
    chk("ar_pc", PC_ctrl, 0);
    br_taken = 0;
    @(negedge clk);
    rst = 1'b1;
    m_init();

    // Halt every thread in turn, then drain to done.
    mcyc(0, 4'h0, 0, 0, 0, 0);
    mcyc(1, 4'hF, 0, 0, 0, 0);
    n = 0;
    zero_cnt = 0;
    while (!all_done && n < 40) begin
      if (active_mask == 0) zero_cnt++;
      mcyc(0, 4'h0, 0, 1, 2'(m_id()), 0);
      n++;
    end
    chk("done_reached", all_done, 1);
    chk("drain_cycles", zero_cnt, 2);

    // Relaunch with only threads 0 and 2.
    mcyc(1, 4'h5, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) mcyc(0, 4'h0, 0, 0, 0, 1);

    for (int i = 0; i < 1500; i++) begin
      bit       s, st, hr, br;
      bit [3:0] init;
      bit [1:0] ht;
      s    = ($urandom % 12) == 0;
      init = 4'($urandom);
      st   = ($urandom % 5) == 0;
      hr   = ($urandom % 4) == 0;
      ht   = (($urandom % 4) == 0) ? 2'($urandom) : 2'(m_id());
      br   = $urandom % 2;
      mcyc(s, init, st, hr, ht, br);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thread_sched.md
Name: thread_sched

Overview:
- Barrel thread scheduler for the 4-thread fine-grained multithreaded pipeline.
- Generates the per-stage thread tags (thread_IF, thread_ID, thread_EX, thread_WB) that the PC unit and downstream stages consume.
- Tracks which threads are still running, turns halted threads into bubbles, and qualifies the branch-taken signal that drives PC_ctrl.
- Sits at the top of the datapath, next to the PC unit.

Parameters:
- NUM_THREADS, 4: number of hardware threads. Must be a power of two.
- TID_W, 2: thread-ID width, equal to log2(NUM_THREADS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse that launches the threads selected by thread_en_init.
- thread_en_init  in  NUM_THREADS  per-thread enable mask, sampled on start.
- stall  in  1  freezes the scheduler for the cycle.
- halt_req  in  1  the instruction in ID is a halt.
- halt_tid  in  TID_W  thread issuing the halt.
- br_taken  in  1  ID-stage branch is resolved taken.
- thread_IF  out  TID_W  thread fetching this cycle.
- thread_ID  out  TID_W  thread in decode.
- thread_EX  out  TID_W  thread in execute.
- thread_WB  out  TID_W  thread in writeback.
- valid_IF, valid_ID, valid_EX, valid_WB  out  1 each  stage holds a real instruction (0 = bubble).
- PC_ctrl  out  1  branch redirect for thread_ID: br_taken AND valid_ID AND NOT stall.
- active_mask  out  NUM_THREADS  threads not yet halted.
- all_done  out  1  all threads halted and the pipeline has drained.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE.
  - thread_IF=0, thread_ID=3, thread_EX=2, thread_WB=1.
  - All valid_* = 0, active_mask=0, all_done=0, PC_ctrl=0.
- Tag relationship: thread_ID = thread_IF-1, thread_EX = thread_IF-2, thread_WB = thread_IF-3, all mod NUM_THREADS. Only thread_IF is a counter; the other tags are derived or shifted consistently.
- Rotation: thread_IF increments by 1 every non-stalled cycle in RUN and DRAIN, wrapping 3 to 0. Tags hold in IDLE and DONE.
- valid_IF is combinational: (state==RUN) AND active_mask[thread_IF].
- Valid pipeline: each non-stalled edge does valid_ID<=valid_IF, valid_EX<=valid_ID, valid_WB<=valid_EX. In IDLE and DONE all valids are forced to 0.
- State machine:
  - IDLE: on start with thread_en_init!=0, active_mask<=thread_en_init and go to RUN; the first fetch is thread 0 in the cycle after start. A start with a zero mask is ignored.
  - RUN: a halt takes effect when halt_req=1, halt_tid==thread_ID, valid_ID=1 and stall=0; active_mask[halt_tid] is cleared at the next edge. A halt whose tid mismatches thread_ID, or with valid_ID=0, is ignored. If the cleared bit leaves active_mask==0, go to DRAIN.
  - DRAIN: rotation continues and valid_IF=0. Go to DONE at the first edge at which valid_ID, valid_EX and valid_WB are all 0 after the shift.
  - DONE: all_done=1 (registered). start behaves as in IDLE and clears all_done at the same edge.
- start outside IDLE or DONE is ignored.
- stall=1:
  - Holds thread tags, valids, active_mask and state.
  - Forces PC_ctrl=0.
  - Halt is not sampled.
  - start is still honoured in IDLE and DONE.
- The barrel spacing guarantees a halted thread's next fetch slot, 3 cycles after its ID slot, sees the cleared mask bit. No younger instruction of that thread is ever fetched.
- Reset asserted mid-run returns to the reset values immediately, regardless of clk.

Decomposition:
- Shared package constants:
  - NUM_THREADS, TID_W.
  - State encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - Reset tag values.
- One natural sub-module: thread_valid_pipe, the 3-stage valid/tag shift register with stall hold. The FSM and rotation counter stay in thread_sched.

Test Plan:
- Reset and IDLE: rst low, then release, with no start. Tags must stay IF=0, ID=3, EX=2, WB=1; all valids 0.
- Start with mask 4'b1111: on the following cycles thread_IF must run 0,1,2,3,0 and thread_ID must run 3,0,1,2,3. valid_IF=1 every cycle; valid_WB first goes to 1 three cycles after the first fetch.
- Halt in ID: when thread_ID=1 with valid_ID=1 and halt_tid=1, bit 1 clears at the next edge. The next IF slot for thread 1 shows valid_IF=0; the other threads are unaffected.
- Halt all threads: halt threads 0,1,2,3 in turn. The FSM enters DRAIN, valid_WB falls within 3 cycles, then all_done=1. A new start with mask 4'b0101 relaunches only threads 0 and 2.
- Branch and stall: br_taken=1 with valid_ID=1 and stall=0 gives PC_ctrl=1. Raising stall for 2 cycles freezes all tags, forces PC_ctrl=0 and ignores a halt_req presented during the stall.
- Mismatched halt and async reset: halt_tid=2 while thread_ID=0 leaves the mask unchanged. Asserting rst mid-RUN, between clock edges, immediately restores all reset values.
